// File: rtl/crop_pkg.sv
// Shared definitions for the crop stage: pixel width, FSM encoding and offset clamp.
package crop_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CROPPING,
        STREAMING
    } state_t;

    // Keeps a requested window offset inside the frame.
    function automatic int unsigned clamp_offset(input int unsigned req, input int unsigned lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/crop_buffer.sv
// Window buffer: simple dual-port RAM with one-cycle registered read, no reset.
module crop_buffer
    import crop_pkg::*;
#(
    parameter int DEPTH  = 100,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // rd_data only moves on rd_en so it can hold a prefetched pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/crop_filter.sv
// Crops a window out of one input frame, tracks its maximum, then streams the window out.
module crop_filter
    import crop_pkg::*;
#(
    parameter int IN_ROWS  = 32,
    parameter int IN_COLS  = 32,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    input  logic [$clog2(IN_ROWS)-1:0] crop_row_start,
    input  logic [$clog2(IN_COLS)-1:0] crop_col_start,
    output logic                       ap_ready,
    output logic                       ap_idle,
    output logic                       ap_done,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [7:0]                 s_axis_tdata,
    input  logic                       s_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic [7:0]                 norm_denominator,
    output logic                       norm_denominator_tvalid
);

    localparam int ROW_W = $clog2(IN_ROWS);
    localparam int COL_W = $clog2(IN_COLS);
    localparam int DEPTH = OUT_ROWS * OUT_COLS;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam logic [ROW_W:0] OUT_ROWS_W = (ROW_W + 1)'(OUT_ROWS);
    localparam logic [COL_W:0] OUT_COLS_W = (COL_W + 1)'(OUT_COLS);

    state_t state_reg, state_next;

    logic [ROW_W-1:0] row_reg, r0_reg;
    logic [COL_W-1:0] col_reg, c0_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, sent_reg;
    logic [PIX_W-1:0] max_reg, den_reg, out_data_reg;
    logic             s1_valid_reg, out_valid_reg, done_reg, den_valid_reg;

    logic             pix_acc, resync, in_win, last_pix;
    logic             out_hs, last_beat, out_load, rd_en;
    logic [ROW_W-1:0] eff_row;
    logic [COL_W-1:0] eff_col;
    logic [PIX_W-1:0] max_base, max_new, rd_data;
    logic [PTR_W-1:0] wr_base;

    // A tuser pixel away from (0,0) restarts the frame at that pixel.
    assign pix_acc  = (state_reg == CROPPING) && s_axis_tvalid;
    assign resync   = s_axis_tuser && ((row_reg != '0) || (col_reg != '0));
    assign eff_row  = resync ? '0 : row_reg;
    assign eff_col  = resync ? '0 : col_reg;
    assign max_base = resync ? '0 : max_reg;
    assign wr_base  = resync ? '0 : wr_ptr_reg;

    assign in_win = (eff_row >= r0_reg)
                 && ((ROW_W + 1)'(eff_row) < ((ROW_W + 1)'(r0_reg) + OUT_ROWS_W))
                 && (eff_col >= c0_reg)
                 && ((COL_W + 1)'(eff_col) < ((COL_W + 1)'(c0_reg) + OUT_COLS_W));

    assign max_new  = (in_win && (s_axis_tdata > max_base)) ? s_axis_tdata : max_base;
    assign last_pix = pix_acc && (eff_row == ROW_W'(IN_ROWS - 1))
                              && (eff_col == COL_W'(IN_COLS - 1));

    // Two-stage read pipe: RAM output register, then the output register.
    assign out_hs    = out_valid_reg && m_axis_tready;
    assign last_beat = out_hs && (sent_reg == PTR_W'(DEPTH - 1));
    assign out_load  = (state_reg == STREAMING) && s1_valid_reg
                    && (!out_valid_reg || m_axis_tready);
    assign rd_en     = (state_reg == STREAMING) && (rd_ptr_reg < PTR_W'(DEPTH))
                    && (!s1_valid_reg || out_load);

    crop_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (pix_acc && in_win),
        .wr_addr (wr_base),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:      if (ap_start)  state_next = CROPPING;
            CROPPING:  if (last_pix)  state_next = STREAMING;
            STREAMING: if (last_beat) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            row_reg       <= '0;
            col_reg       <= '0;
            r0_reg        <= '0;
            c0_reg        <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            sent_reg      <= '0;
            max_reg       <= '0;
            den_reg       <= '0;
            den_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (ap_start) begin
                        r0_reg        <= ROW_W'(clamp_offset(32'(crop_row_start), IN_ROWS - OUT_ROWS));
                        c0_reg        <= COL_W'(clamp_offset(32'(crop_col_start), IN_COLS - OUT_COLS));
                        row_reg       <= '0;
                        col_reg       <= '0;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        sent_reg      <= '0;
                        max_reg       <= '0;
                        s1_valid_reg  <= 1'b0;
                        den_valid_reg <= 1'b0;
                    end
                end
                CROPPING: begin
                    if (pix_acc) begin
                        if (eff_col == COL_W'(IN_COLS - 1)) begin
                            col_reg <= '0;
                            row_reg <= eff_row + 1'b1;
                        end else begin
                            col_reg <= eff_col + 1'b1;
                            row_reg <= eff_row;
                        end
                        max_reg    <= max_new;
                        wr_ptr_reg <= in_win ? wr_base + 1'b1 : wr_base;
                        if (last_pix) begin
                            done_reg      <= 1'b1;
                            den_valid_reg <= 1'b1;
                            den_reg       <= (max_new == '0) ? PIX_W'(1) : max_new;
                        end
                    end
                end
                STREAMING: begin
                    if (rd_en) begin
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        s1_valid_reg <= 1'b1;
                    end else if (out_load) begin
                        s1_valid_reg <= 1'b0;
                    end
                    if (out_load) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= rd_data;
                    end else if (m_axis_tready) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (out_hs) begin
                        sent_reg <= sent_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_ready                = (state_reg == IDLE);
    assign ap_idle                 = (state_reg == IDLE);
    assign ap_done                 = done_reg;
    assign s_axis_tready           = (state_reg == CROPPING);
    assign m_axis_tvalid           = out_valid_reg;
    assign m_axis_tdata            = out_data_reg;
    assign norm_denominator        = den_reg;
    assign norm_denominator_tvalid = den_valid_reg;

endmodule
